// File: rtl/minmax_reduce_ctrl_if.sv
// Handshake and result bundle for the signed min/max frame reducer.
interface minmax_reduce_ctrl_if #(
    parameter int WIDTH     = 8,
    parameter int MAX_COUNT = 16
);
    localparam int CW = $clog2(MAX_COUNT) + 1;

    logic                    start;
    logic                    in_valid;
    logic                    in_ready;
    logic signed [WIDTH-1:0] in_data;
    logic                    in_active;
    logic                    in_last;
    logic signed [WIDTH-1:0] max_out;
    logic signed [WIDTH-1:0] min_out;
    logic                    result_active;
    logic [CW-1:0]           count_out;
    logic                    overflow;
    logic                    out_valid;
    logic                    out_ready;
    logic                    busy;

    modport slave (
        input  start, in_valid, in_data, in_active, in_last, out_ready,
        output in_ready, max_out, min_out, result_active, count_out,
               overflow, out_valid, busy
    );

    modport master (
        output start, in_valid, in_data, in_active, in_last, out_ready,
        input  in_ready, max_out, min_out, result_active, count_out,
               overflow, out_valid, busy
    );
endinterface

// File: rtl/minmax_reduce_ctrl.sv
// Frame-based signed min/max reducer: accumulates active beats of a frame and
// presents max/min/count with a valid/ready result handshake.
module minmax_reduce_ctrl #(
    parameter int WIDTH     = 8,
    parameter int MAX_COUNT = 16
) (
    input  logic                 clk,
    input  logic                 rst_n,
    minmax_reduce_ctrl_if.slave  bus
);
    localparam int CW = $clog2(MAX_COUNT) + 1;
    localparam logic signed [WIDTH-1:0] SMIN     = {1'b1, {(WIDTH-1){1'b0}}};
    localparam logic signed [WIDTH-1:0] SMAX     = {1'b0, {(WIDTH-1){1'b1}}};
    localparam logic [CW-1:0]           LAST_CNT = CW'(MAX_COUNT - 1);

    typedef enum logic [1:0] {IDLE, ACCUM, DONE} state_t;

    state_t                  state_q, state_d;
    logic signed [WIDTH-1:0] max_q, max_d;
    logic signed [WIDTH-1:0] min_q, min_d;
    logic                    act_q, act_d;
    logic [CW-1:0]           cnt_q, cnt_d;
    logic                    ovf_q, ovf_d;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            max_q   <= SMIN;
            min_q   <= SMAX;
            act_q   <= 1'b0;
            cnt_q   <= '0;
            ovf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            max_q   <= max_d;
            min_q   <= min_d;
            act_q   <= act_d;
            cnt_q   <= cnt_d;
            ovf_q   <= ovf_d;
        end
    end

    always_comb begin
        state_d = state_q;
        max_d   = max_q;
        min_d   = min_q;
        act_d   = act_q;
        cnt_d   = cnt_q;
        ovf_d   = ovf_q;
        case (state_q)
            IDLE: begin
                if (bus.start) begin
                    state_d = ACCUM;
                    max_d   = SMIN;
                    min_d   = SMAX;
                    act_d   = 1'b0;
                    cnt_d   = '0;
                    ovf_d   = 1'b0;
                end
            end
            ACCUM: begin
                // in_ready is high for the whole of ACCUM, so in_valid alone is the handshake.
                if (bus.in_valid) begin
                    cnt_d = cnt_q + 1'b1;
                    if (bus.in_active) begin
                        if ($signed(bus.in_data) > max_q) max_d = bus.in_data;
                        if ($signed(bus.in_data) < min_q) min_d = bus.in_data;
                        act_d = 1'b1;
                    end
                    if (bus.in_last) begin
                        state_d = DONE;
                    end else if (cnt_q == LAST_CNT) begin
                        state_d = DONE;
                        ovf_d   = 1'b1;
                    end
                end
            end
            DONE: begin
                if (bus.out_ready) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    assign bus.in_ready      = (state_q == ACCUM);
    assign bus.out_valid     = (state_q == DONE);
    assign bus.busy          = (state_q != IDLE);
    assign bus.max_out       = max_q;
    assign bus.min_out       = min_q;
    assign bus.result_active = act_q;
    assign bus.count_out     = cnt_q;
    assign bus.overflow      = ovf_q;
endmodule

// File: tb/tb_minmax_reduce_ctrl.sv
// Scoreboard bench for minmax_reduce_ctrl: directed frames plus random frames.
module tb_minmax_reduce_ctrl;
    localparam int W  = 8;
    localparam int MC = 16;

    typedef struct {
        int mx;
        int mn;
        bit act;
        int cnt;
        bit ovf;
    } res_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    minmax_reduce_ctrl_if #(.WIDTH(W), .MAX_COUNT(MC)) bus ();
    minmax_reduce_ctrl #(.WIDTH(W), .MAX_COUNT(MC)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    res_t sb_q[$];
    int   checks = 0;
    int   errors = 0;
    int   frames_done = 0;

    int   fd[$];
    bit   fa[$];
    bit   flast;

    task automatic chk(input string name, input int actual, input int expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, actual, expected, $time);
        end
    endtask

    // Reference: plain fold over the frame's active values.
    function automatic res_t model();
        res_t r;
        r.mx  = -(1 << (W-1));
        r.mn  = (1 << (W-1)) - 1;
        r.act = 1'b0;
        for (int i = 0; i < fd.size(); i++) begin
            if (fa[i]) begin
                if (fd[i] > r.mx) r.mx = fd[i];
                if (fd[i] < r.mn) r.mn = fd[i];
                r.act = 1'b1;
            end
        end
        r.cnt = fd.size();
        r.ovf = (fd.size() == MC) && !flast;
        return r;
    endfunction

    always @(negedge clk) begin
        if (rst_n && bus.out_valid) begin
            if (sb_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_result: out_valid=1 expected no pending frame at %0t", $time);
            end else begin
                chk("max_out", int'($signed(bus.max_out)), sb_q[0].mx);
                chk("min_out", int'($signed(bus.min_out)), sb_q[0].mn);
                chk("result_active", int'(bus.result_active), int'(sb_q[0].act));
                chk("count_out", int'(bus.count_out), sb_q[0].cnt);
                chk("overflow", int'(bus.overflow), int'(sb_q[0].ovf));
                if (bus.out_ready) begin
                    frames_done++;
                    $display("frame %0d: max=%0d min=%0d act=%0b cnt=%0d ovf=%0b",
                             frames_done, $signed(bus.max_out), $signed(bus.min_out),
                             bus.result_active, bus.count_out, bus.overflow);
                    void'(sb_q.pop_front());
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic run_frame(input int hold, input bit gaps, input bit idle_valid, input bit pulses);
        sb_q.push_back(model());
        bus.start     = 1'b1;
        bus.in_valid  = idle_valid;
        bus.in_data   = 8'sh5a;
        bus.in_active = 1'b1;
        bus.in_last   = 1'b1;
        tick();
        bus.start    = 1'b0;
        bus.in_valid = 1'b0;
        for (int i = 0; i < fd.size(); i++) begin
            if (gaps) begin
                repeat ($urandom_range(0, 2)) begin
                    bus.in_valid = 1'b0;
                    tick();
                end
            end
            bus.in_valid  = 1'b1;
            bus.in_data   = W'(fd[i]);
            bus.in_active = fa[i];
            bus.in_last   = (i == fd.size() - 1) && flast;
            bus.start     = pulses;
            tick();
        end
        bus.start    = 1'b0;
        bus.in_valid = idle_valid;
        bus.in_last  = 1'b0;
        chk("latency_out_valid", int'(bus.out_valid), 1);
        chk("done_in_ready", int'(bus.in_ready), 0);
        bus.out_ready = 1'b0;
        for (int i = 0; i < hold; i++) begin
            bus.start = pulses && (i % 2 == 0);
            tick();
            chk("hold_out_valid", int'(bus.out_valid), 1);
        end
        bus.start     = 1'b0;
        bus.out_ready = 1'b1;
        tick();
        bus.out_ready = 1'b0;
        chk("release_out_valid", int'(bus.out_valid), 0);
        chk("release_busy", int'(bus.busy), 0);
    endtask

    task automatic check_reset_values(input string tag);
        chk({tag, "_in_ready"}, int'(bus.in_ready), 0);
        chk({tag, "_out_valid"}, int'(bus.out_valid), 0);
        chk({tag, "_busy"}, int'(bus.busy), 0);
        chk({tag, "_overflow"}, int'(bus.overflow), 0);
        chk({tag, "_result_active"}, int'(bus.result_active), 0);
        chk({tag, "_count_out"}, int'(bus.count_out), 0);
        chk({tag, "_max_out"}, int'($signed(bus.max_out)), -128);
        chk({tag, "_min_out"}, int'($signed(bus.min_out)), 127);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached with %0d frames pending", sb_q.size());
        $fatal(1, "watchdog");
    end

    initial begin
        bus.start     = 1'b0;
        bus.in_valid  = 1'b0;
        bus.in_data   = '0;
        bus.in_active = 1'b0;
        bus.in_last   = 1'b0;
        bus.out_ready = 1'b0;
        #12;
        check_reset_values("por");
        tick();
        rst_n = 1'b1;
        tick();

        fd = '{-1, -2, 5, 3}; fa = '{1, 1, 0, 1}; flast = 1'b1;
        run_frame(0, 1'b0, 1'b0, 1'b0);

        fd = '{1, 2}; fa = '{0, 0}; flast = 1'b1;
        run_frame(1, 1'b0, 1'b0, 1'b0);

        fd.delete(); fa.delete();
        for (int i = 0; i < MC; i++) begin
            fd.push_back(i);
            fa.push_back(1'b1);
        end
        flast = 1'b0;
        run_frame(0, 1'b0, 1'b0, 1'b0);

        fd = '{-128}; fa = '{1}; flast = 1'b1;
        run_frame(5, 1'b0, 1'b0, 1'b1);

        // Abort a frame by asynchronous reset between clock edges.
        bus.start = 1'b1;
        tick();
        bus.start = 1'b0;
        for (int i = 0; i < 3; i++) begin
            bus.in_valid  = 1'b1;
            bus.in_data   = W'(10 * (i + 1));
            bus.in_active = 1'b1;
            bus.in_last   = 1'b0;
            tick();
        end
        bus.in_valid = 1'b0;
        chk("pre_reset_count", int'(bus.count_out), 3);
        #2;
        rst_n = 1'b0;
        #1;
        check_reset_values("mid_reset");
        tick();
        rst_n = 1'b1;
        fd = '{7}; fa = '{1}; flast = 1'b1;
        run_frame(0, 1'b0, 1'b0, 1'b0);

        fd = '{4, -9, 100, 0, -3}; fa = '{1, 1, 0, 1, 1}; flast = 1'b1;
        run_frame(2, 1'b1, 1'b1, 1'b0);
        bus.in_valid = 1'b0;

        fd = '{-50, 60}; fa = '{1, 1};
        for (int i = 2; i < MC; i++) begin
            fd.push_back(60 - i);
            fa.push_back(1'b1);
        end
        flast = 1'b1;
        run_frame(0, 1'b0, 1'b0, 1'b0);

        for (int f = 0; f < 40; f++) begin
            int n;
            flast = ($urandom_range(0, 3) != 0);
            n = flast ? int'($urandom_range(1, MC)) : MC;
            fd.delete(); fa.delete();
            for (int i = 0; i < n; i++) begin
                case ($urandom_range(0, 5))
                    0:       fd.push_back(-128);
                    1:       fd.push_back(127);
                    default: fd.push_back(int'($urandom_range(0, 255)) - 128);
                endcase
                fa.push_back($urandom_range(0, 2) != 0);
            end
            run_frame(int'($urandom_range(0, 3)), bit'($urandom_range(0, 1)),
                      bit'($urandom_range(0, 1)), bit'($urandom_range(0, 1)));
        end
        bus.in_valid = 1'b0;

        tick();
        checks++;
        if (sb_q.size() != 0) begin
            errors++;
            $display("FAIL scoreboard_drain: %0d frames pending, expected 0", sb_q.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
